// File: rtl/frame_wr_pattern_gen_if.sv
// Purpose : bus between the frame write-pattern generator and its SDRAM write-FIFO / control side.
// Latency : none, wires only.
// Backpressure: Fifo_full from the FIFO side gates FIFO_WR_EN in the same cycle.
// Signals : Init_done, Start, Mode, Fifo_full        -> into the generator
//           FIFO_WR_EN, FIFO_WR_data, Pix_cnt, Line_cnt, Busy, Frame_done -> out of the generator
// Modports: master = generator side, slave = controller / FIFO side.
interface frame_wr_pattern_gen_if #(
  parameter int DATA_W = 8,
  parameter int PIX_W  = 10,
  parameter int LINE_W = 9
);
  logic              Init_done;
  logic              Start;
  logic [1:0]        Mode;
  logic              Fifo_full;
  logic              FIFO_WR_EN;
  logic [DATA_W-1:0] FIFO_WR_data;
  logic [PIX_W-1:0]  Pix_cnt;
  logic [LINE_W-1:0] Line_cnt;
  logic              Busy;
  logic              Frame_done;

  modport master (
    input  Init_done, Start, Mode, Fifo_full,
    output FIFO_WR_EN, FIFO_WR_data, Pix_cnt, Line_cnt, Busy, Frame_done
  );

  modport slave (
    output Init_done, Start, Mode, Fifo_full,
    input  FIFO_WR_EN, FIFO_WR_data, Pix_cnt, Line_cnt, Busy, Frame_done
  );
endinterface

// File: rtl/frame_wr_pattern_gen.sv
// Purpose : generates one test-pattern frame (H_ACTIVE x V_ACTIVE pixels) into an SDRAM write FIFO.
// Latency : first write START_DLY+1 cycles after Init_done is seen high in WAIT_INIT (START_DLY+2 after Start).
// Backpressure: Fifo_full combinationally blocks FIFO_WR_EN; pixel counter and data hold while full.
// Ports   : Sys_clk, Rst_n (async, active-low), bus (frame_wr_pattern_gen_if.master).
// Option  : PATGEN_CONTINUOUS_EN defined -> frames repeat back-to-back without Start until reset.
module frame_wr_pattern_gen #(
  parameter int DATA_W    = 8,
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int LINE_GAP  = 1000,
  parameter int START_DLY = 5
) (
  input  logic                   Sys_clk,
  input  logic                   Rst_n,
  frame_wr_pattern_gen_if.master bus
);

  localparam int PIX_W  = (H_ACTIVE  > 1) ? $clog2(H_ACTIVE)  : 1;
  localparam int LINE_W = (V_ACTIVE  > 1) ? $clog2(V_ACTIVE)  : 1;
  localparam int GAP_W  = (LINE_GAP  > 1) ? $clog2(LINE_GAP)  : 1;
  localparam int DLY_W  = (START_DLY > 1) ? $clog2(START_DLY) : 1;

  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(H_ACTIVE - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(V_ACTIVE - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((LINE_GAP  > 0) ? LINE_GAP  - 1 : 0);
  localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'((START_DLY > 0) ? START_DLY - 1 : 0);

`ifdef PATGEN_CONTINUOUS_EN
  localparam bit CONTINUOUS = 1'b1;
`else
  localparam bit CONTINUOUS = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_INIT,
    S_DLY,
    S_LINE,
    S_GAP,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [1:0]        mode_q;
  logic [PIX_W-1:0]  pix_q;
  logic [LINE_W-1:0] line_q;
  logic [GAP_W-1:0]  gap_q;
  logic [DLY_W-1:0]  dly_q;
  logic              busy_q;
  logic              done_q;

  // A zero start delay skips the DLY state entirely.
  localparam state_t FIRST_ACTIVE = (START_DLY == 0) ? S_LINE : S_DLY;

  always_ff @(posedge Sys_clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= 2'd0;
      pix_q   <= '0;
      line_q  <= '0;
      gap_q   <= '0;
      dly_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.Start) begin
            mode_q  <= bus.Mode;
            busy_q  <= 1'b1;
            state_q <= S_WAIT_INIT;
          end
        end

        S_WAIT_INIT: begin
          if (bus.Init_done) begin
            dly_q   <= '0;
            pix_q   <= '0;
            line_q  <= '0;
            state_q <= FIRST_ACTIVE;
          end
        end

        S_DLY: begin
          if (dly_q == DLY_LAST) begin
            state_q <= S_LINE;
          end else begin
            dly_q <= dly_q + DLY_W'(1);
          end
        end

        S_LINE: begin
          // A cycle with Fifo_full high is a stall: nothing advances.
          if (!bus.Fifo_full) begin
            if (pix_q == PIX_LAST) begin
              pix_q <= '0;
              if (LINE_GAP == 0) begin
                if (line_q == LINE_LAST) begin
                  line_q  <= '0;
                  done_q  <= 1'b1;
                  busy_q  <= CONTINUOUS;
                  state_q <= S_DONE;
                end else begin
                  line_q <= line_q + LINE_W'(1);
                end
              end else begin
                gap_q   <= '0;
                state_q <= S_GAP;
              end
            end else begin
              pix_q <= pix_q + PIX_W'(1);
            end
          end
        end

        S_GAP: begin
          // Gap length is fixed in cycles; Fifo_full has no effect here.
          if (gap_q == GAP_LAST) begin
            if (line_q == LINE_LAST) begin
              line_q  <= '0;
              done_q  <= 1'b1;
              busy_q  <= CONTINUOUS;
              state_q <= S_DONE;
            end else begin
              line_q  <= line_q + LINE_W'(1);
              state_q <= S_LINE;
            end
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end

        S_DONE: begin
          if (CONTINUOUS) begin
            mode_q  <= bus.Mode;
            dly_q   <= '0;
            state_q <= FIRST_ACTIVE;
          end else begin
            state_q <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Pattern is a pure function of registered counters and latched mode, so it
  // is zero whenever the counters are zero (reset, idle, between frames).
  logic [15:0] pix_ext;
  logic [15:0] line_ext;
  logic [15:0] pat;

  always_comb begin
    pix_ext  = 16'(pix_q);
    line_ext = 16'(line_q);
    case (mode_q)
      2'd0:    pat = pix_ext;
      2'd1:    pat = line_ext;
      2'd2:    pat = {16{pix_ext[3] ^ line_ext[3]}};
      default: pat = pix_ext ^ line_ext;
    endcase
  end

  assign bus.FIFO_WR_EN   = (state_q == S_LINE) && !bus.Fifo_full;
  assign bus.FIFO_WR_data = DATA_W'(pat);
  assign bus.Pix_cnt      = pix_q;
  assign bus.Line_cnt     = line_q;
  assign bus.Busy         = busy_q;
  assign bus.Frame_done   = done_q;

endmodule
